// File: rtl/seq_pkg.sv
// Shared types and helpers for the step sequencer: FSM state encoding,
// index-width derivation and duty clamping.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    PLAY
  } seq_state_t;

  // Width of an index able to address n entries; never narrower than one bit.
  function automatic int unsigned step_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] clamp_duty(input logic [31:0] d, input logic [31:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/seq_step_engine_timer.sv
// Per-step tick counter: flags the last tick of a step and whether the gate
// window still covers the next tick.
module step_timer
  import seq_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 1500000,
  parameter int unsigned GATE_TICKS = 750000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic step_end,
  output logic gate_on
);

  localparam int unsigned TW = step_idx_w(STEP_TICKS);
  localparam logic [TW-1:0] LAST      = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TICKS - 1);

  logic [TW-1:0] tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (restart || !en || step_end) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign step_end = (tick == LAST);
  // High while tick+1 < GATE_TICKS, so the registered gate falls exactly on tick GATE_TICKS.
  assign gate_on  = (tick < GATE_LAST);

endmodule

// File: rtl/seq_step_engine.sv
// Step sequencer feeding the PWM compare stage: plays an 8-entry duty pattern
// at a fixed tempo with a load strobe, gate indicator and busy flag.
module seq_step_engine
  import seq_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned DUTY_W       = 11,
  parameter int unsigned NUM_STEPS    = 8,
  parameter int unsigned STEP_TICKS   = 1500000,
  parameter int unsigned GATE_TICKS   = 750000,
  localparam int unsigned IW          = step_idx_w(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_vld,
  output logic [IW-1:0]     step_idx,
  output logic              gate,
  output logic              busy
);

  seq_state_t        state;
  logic [DUTY_W-1:0] pattern [NUM_STEPS];
  logic [DUTY_W-1:0] wr_val;
  logic [IW-1:0]     load_idx;
  logic [DUTY_W-1:0] load_duty;
  logic              step_end;
  logic              gate_on;
  logic              load;

  assign wr_val = DUTY_W'(clamp_duty(32'(wr_data), 32'(PWM_INTERVAL)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (wr_en) begin
      pattern[wr_addr] <= wr_val;
    end
  end

  // A load reads the pre-edge pattern, so a same-edge write only shows on the next pass.
  assign load_idx  = (state == START) ? '0 : step_idx + IW'(1);
  assign load_duty = pattern[load_idx];
  assign load      = (state == START) || ((state == PLAY) && step_end && run);

  step_timer #(
    .STEP_TICKS(STEP_TICKS),
    .GATE_TICKS(GATE_TICKS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .en      (state == PLAY),
    .step_end(step_end),
    .gate_on (gate_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty     <= '0;
      duty_vld <= 1'b0;
      step_idx <= '0;
      gate     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      duty_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START, PLAY: begin
          if (load) begin
            state    <= PLAY;
            duty     <= load_duty;
            step_idx <= load_idx;
            gate     <= (load_duty != '0);
            duty_vld <= 1'b1;
          end else if (step_end) begin
            state    <= IDLE;
            duty     <= '0;
            step_idx <= '0;
            gate     <= 1'b0;
            busy     <= 1'b0;
            duty_vld <= 1'b1;
          end else begin
            gate <= gate & gate_on;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_engine.sv
// Directed bench for seq_step_engine with a short step (10 clocks, 4-clock gate).
module tb_seq_step_engine;

  localparam int unsigned STEP_T = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [10:0] wr_data;
  logic [10:0] duty;
  logic        duty_vld;
  logic [2:0]  step_idx;
  logic        gate;
  logic        busy;

  seq_step_engine #(
    .PWM_INTERVAL(1200),
    .DUTY_W      (11),
    .NUM_STEPS   (8),
    .STEP_TICKS  (10),
    .GATE_TICKS  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .duty    (duty),
    .duty_vld(duty_vld),
    .step_idx(step_idx),
    .gate    (gate),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [10:0] data;
    logic [10:0] exp_duty;
  } vec_t;

  vec_t        vecs [8];
  logic [10:0] model [8];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a load edge; leaves just after the following load edge.
  task automatic play_step(input int s, input logic do_wr, input logic [2:0] a,
                           input logic [10:0] d);
    logic [10:0] ed;
    int          eg;
    ed = model[s % 8];
    eg = (ed != 0) ? 1 : 0;
    check($sformatf("s%0d duty", s), duty, ed);
    check($sformatf("s%0d vld", s), duty_vld, 1);
    check($sformatf("s%0d idx", s), step_idx, s % 8);
    check($sformatf("s%0d gate", s), gate, eg);
    check($sformatf("s%0d busy", s), busy, 1);
    for (int t = 1; t < STEP_T; t++) begin
      step_clk();
      if (t == 3) check($sformatf("s%0d gate_t3", s), gate, eg);
      if (t == 4) check($sformatf("s%0d gate_t4", s), gate, 0);
      if (t == 9) check($sformatf("s%0d vld_t9", s), duty_vld, 0);
    end
    if (do_wr) begin
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
    end
    step_clk();
    wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 11'd100,  11'd100};
    vecs[1] = '{3'd1, 11'd200,  11'd200};
    vecs[2] = '{3'd2, 11'd0,    11'd0};
    vecs[3] = '{3'd3, 11'd2000, 11'd1200};
    vecs[4] = '{3'd4, 11'd5,    11'd5};
    vecs[5] = '{3'd5, 11'd6,    11'd6};
    vecs[6] = '{3'd6, 11'd7,    11'd7};
    vecs[7] = '{3'd7, 11'd8,    11'd8};
    for (int i = 0; i < 8; i++) model[i] = '0;

    rst_n = 1'b0; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) step_clk();
    check("rst duty", duty, 0);
    check("rst vld", duty_vld, 0);
    check("rst idx", step_idx, 0);
    check("rst gate", gate, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    step_clk();

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      step_clk();
      model[vecs[i].addr] = vecs[i].exp_duty;
    end
    wr_en = 1'b0;
    step_clk();
    check("idle duty", duty, 0);
    check("idle busy", busy, 0);

    run = 1'b1;
    step_clk();
    check("start busy", busy, 1);
    check("start vld", duty_vld, 0);
    check("start duty", duty, 0);
    step_clk();

    // Collision: write 999 to step 1 on the edge that loads step 1 (second pass).
    for (int s = 0; s <= 20; s++) begin
      play_step(s, (s == 8), 3'd1, 11'd999);
      if (s == 9) model[1] = 11'd999;
    end

    // Step 21 is step 5; drop run at tick 3, step must still run its full length.
    check("stop s5 duty", duty, 6);
    check("stop s5 idx", step_idx, 5);
    repeat (3) step_clk();
    run = 1'b0;
    repeat (6) step_clk();
    check("stop t9 busy", busy, 1);
    check("stop t9 duty", duty, 6);
    check("stop t9 vld", duty_vld, 0);
    step_clk();
    check("stop duty", duty, 0);
    check("stop vld", duty_vld, 1);
    check("stop busy", busy, 0);
    check("stop idx", step_idx, 0);
    check("stop gate", gate, 0);
    step_clk();
    check("idle2 vld", duty_vld, 0);
    check("idle2 busy", busy, 0);

    // Asynchronous reset mid-PLAY.
    run = 1'b1;
    step_clk();
    step_clk();
    check("rp duty", duty, 100);
    repeat (2) step_clk();
    check("rp gate", gate, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst duty", duty, 0);
    check("arst gate", gate, 0);
    check("arst busy", busy, 0);
    check("arst idx", step_idx, 0);
    check("arst vld", duty_vld, 0);
    step_clk();
    rst_n = 1'b1;
    step_clk();
    check("rr busy", busy, 1);
    step_clk();
    check("rr vld", duty_vld, 1);
    check("rr duty", duty, 0);
    check("rr gate", gate, 0);
    repeat (STEP_T) step_clk();
    check("rr s1 idx", step_idx, 1);
    check("rr s1 duty", duty, 0);
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
